// File: rtl/myproject_dense_mac_sched.sv
// myproject_dense_mac_sched: time-multiplexed dot-product scheduler driving one shared multiplier
module myproject_dense_mac_sched #(
    parameter int N_IN   = 16,
    parameter int DATA_W = 12,
    parameter int WGT_W  = 9,
    parameter int PROD_W = 21,
    parameter int ACC_W  = 25,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [IDX_W-1:0]  w_addr,
    input  logic [WGT_W-1:0]  w_data,
    output logic [DATA_W-1:0] mul_a,
    output logic [WGT_W-1:0]  mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    typedef enum logic [1:0] {RUN, DRAIN, OUT} state_t;
    state_t              r_state, w_next;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_s1_data;
    logic                r_s1_valid;
    logic [ACC_W-1:0]    r_acc, r_out_data, w_acc_sum;
    logic                r_out_valid, w_accept, w_last, w_hs;
    assign in_ready  = (r_state == RUN) && !ap_rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = r_idx == IDX_W'(N_IN - 1);
    assign w_hs      = (r_state == OUT) && out_ready;
    assign w_addr    = r_idx;
    assign mul_a     = r_s1_valid ? r_s1_data : '0;
    assign mul_b     = r_s1_valid ? w_data : '0;
    assign w_acc_sum = r_acc + {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    // next state: last accept drains one cycle, output waits for its handshake
    always_comb begin
        w_next = (r_state == RUN && w_accept && w_last) ? DRAIN :
                 (r_state == DRAIN) ? OUT :
                 w_hs ? RUN : r_state;
    end
    // element capture, accumulation and result register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= RUN;
            r_idx       <= '0;
            r_s1_data   <= '0;
            r_s1_valid  <= 1'b0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= in_data;
                r_idx     <= w_last ? '0 : r_idx + 1'b1;
            end
            if (w_hs)
                r_acc <= '0;
            else if (r_s1_valid)
                r_acc <= w_acc_sum;
            if (r_state == DRAIN) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_sum;
            end else if (w_hs)
                r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_myproject_dense_mac_sched.sv
// tb_myproject_dense_mac_sched: randomized self-checking bench with weight ROM and multiplier models
module tb_myproject_dense_mac_sched;
    localparam int N = 16;
    logic        ap_clk = 0, ap_rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [11:0] in_data = 0, mul_a;
    logic [3:0]  w_addr;
    logic [8:0]  w_data = 0, mul_b;
    logic [20:0] mul_p;
    logic [24:0] out_data;
    logic [11:0] vd [N];
    logic signed [8:0] w [N];
    int checks = 0, failures = 0;
    bit tog;

    myproject_dense_mac_sched dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .w_addr(w_addr), .w_data(w_data), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) w_data <= w[w_addr];
    assign mul_p = 21'($signed({1'b0, mul_a}) * $signed(mul_b));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic int ref_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(vd[i]) * int'(w[i]);
        return s;
    endfunction

    // mode 0: always valid, 1: every other cycle, 2: random bubbles
    task automatic send_vec(input int mode, input int n);
        tog = 0;
        for (int i = 0; i < n; i++) begin
            bit done = 0;
            int tries = 0;
            while (!done) begin
                bit v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
                tog = ~tog;
                in_valid = v;
                in_data = v ? vd[i] : 12'($urandom);
                if (v && in_ready) begin
                    chk("w_addr", int'(w_addr), i);
                    done = 1;
                end
                cycle();
                if (!done && ++tries > 64) begin
                    chk("accept_timeout", 0, 1);
                    in_valid = 0;
                    return;
                end
            end
        end
        in_valid = 0;
    endtask

    task automatic finish_vec(input int exp, input int hold, input logic keep);
        chk("drain_in_ready", int'(in_ready), 0);
        chk("drain_out_valid", int'(out_valid), 0);
        cycle();
        chk("out_valid", int'(out_valid), 1);
        chk("out_data", int'($signed(out_data)), exp);
        for (int k = 0; k < hold; k++) begin
            cycle();
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_out_data", int'($signed(out_data)), exp);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1;
        cycle();
        out_ready = keep;
        chk("post_hs_out_valid", int'(out_valid), 0);
        chk("post_hs_in_ready", int'(in_ready), 1);
    endtask

    task automatic vec_ones();
        for (int i = 0; i < N; i++) begin
            vd[i] = 1;
            w[i] = 9'(i);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) w[i] = 0;
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_mul_a", int'(mul_a), 0);
        #2 ap_rst = 0;
        cycle();
        chk("run_in_ready", int'(in_ready), 1);
        vec_ones();
        send_vec(0, N);
        finish_vec(120, 0, 0);
        for (int i = 0; i < N; i++) begin
            vd[i] = 12'd4095;
            w[i] = -9'sd256;
        end
        send_vec(0, N);
        finish_vec(-16773120, 0, 0);
        vec_ones();
        send_vec(1, N);
        finish_vec(120, 0, 0);
        vec_ones();
        send_vec(0, N);
        finish_vec(120, 5, 0);
        for (int i = 0; i < N; i++) begin
            vd[i] = 12'd100;
            w[i] = (i % 2 == 0) ? 9'sd255 : -9'sd256;
        end
        chk("model_alt", ref_sum(), -800);
        send_vec(0, N);
        finish_vec(-800, 0, 0);
        vec_ones();
        send_vec(0, 7);
        #2 ap_rst = 1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_w_addr", int'(w_addr), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        @(posedge ap_clk);
        #3 ap_rst = 0;
        #1;
        chk("rel_in_ready", int'(in_ready), 1);
        cycle();
        send_vec(0, N);
        finish_vec(120, 0, 0);
        out_ready = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                vd[i] = 12'($urandom);
                w[i] = 9'($urandom);
            end
            send_vec(0, N);
            finish_vec(ref_sum(), 0, 1);
        end
        out_ready = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) begin
                vd[i] = 12'($urandom);
                w[i] = 9'($urandom);
            end
            send_vec(2, N);
            finish_vec(ref_sum(), $urandom_range(0, 3), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
